fabric_port_arbiter: RTL and testbench
======================================

Name: fabric_port_arbiter

Overview:
Round-robin, burst-atomic arbiter that lets NUM_REQ RTL modules share the RTL-side input of one fabric port, so several modules can inject packets into a single NoC router.
Each requester presents a full RTL-width packet (4 NoC flits wide) with valid/ready and a last marker.
A multi-packet burst from one requester is never interleaved with another requester's packets.
The winning packet is registered once and presented to the fabric port with valid/ready, at one packet per cycle.

Parameters:
WIDTH_NOC, 8, NoC flit width
WIDTH_RTL, 4*WIDTH_NOC, packet width on every requester and on the output
NUM_REQ, 4, number of requesters (any value >= 1, not required to be a power of two)
REQ_ID_WIDTH, max(1,$clog2(NUM_REQ)), width of requester index

Ports:
clk  input  1  single clock (RTL clock domain)
rst  input  1  reset, asynchronous, active-low
req_packet_in  input  NUM_REQ*WIDTH_RTL  requester i's packet in bits [i*WIDTH_RTL +: WIDTH_RTL]
req_valid_in  input  NUM_REQ  requester i has a packet
req_last_in  input  NUM_REQ  packet is the final one of requester i's burst (1 = single-packet burst)
req_ready_out  output  NUM_REQ  packet from requester i accepted this cycle when valid&ready
rtl_packet_out  output  WIDTH_RTL  registered packet to fabric port
rtl_valid_out  output  1  rtl_packet_out valid
rtl_last_out  output  1  registered copy of accepted last bit
rtl_grant_id_out  output  REQ_ID_WIDTH  index of requester that sourced rtl_packet_out
rtl_ready_in  input  1  fabric port accepts the packet

Behaviour:
- Reset (rst=0, async):
  - rtl_valid_out=0, rtl_packet_out=0, rtl_last_out=0, rtl_grant_id_out=0.
  - rr_ptr=0, owner=0, state=ARB_IDLE.
  - req_ready_out=0 for as long as rst=0.
- Reset asserted mid-burst drops the lock and discards any registered packet. No recovery state is kept.
- Definitions:
  - load = !rtl_valid_out | rtl_ready_in
  - transfer on requester i = req_valid_in[i] & req_ready_out[i]
- Output stage:
  - On transfer, register the packet, last bit and id. Set rtl_valid_out=1.
  - If rtl_ready_in=1 and there is no transfer, set rtl_valid_out=0.
  - While rtl_valid_out=1 and rtl_ready_in=0, all output fields hold stable.
  - Latency is 1 cycle from input transfer to rtl_valid_out. Back-to-back transfers are allowed (throughput 1/cycle).
- FSM state ARB_IDLE:
  - g = first i with req_valid_in[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - If any requester is valid and load=1: req_ready_out[g]=1, all other bits 0.
    - With req_last_in[g]=1: stay ARB_IDLE, rr_ptr <= (g+1) mod NUM_REQ.
    - Otherwise: owner <= g, go to ARB_LOCKED, rr_ptr unchanged.
  - If no requester is valid or load=0: all ready bits 0, no state change.
- FSM state ARB_LOCKED:
  - req_ready_out[owner]=load. All other ready bits are 0, even if the owner is not valid.
  - Transfer with last=1: go to ARB_IDLE, rr_ptr <= (owner+1) mod NUM_REQ.
  - Transfer with last=0: stay.
  - Owner dropping valid mid-burst holds the lock indefinitely; there is no timeout.
- Wrap-around: rr_ptr and owner+1 wrap from NUM_REQ-1 to 0 for any NUM_REQ, e.g. 3.
- NUM_REQ=1 degenerates to a pipeline register plus lock FSM.
- req_ready_out is combinational from state, rr_ptr, req_valid_in and rtl_ready_in. It never depends on req_packet_in.
- No requester waits more than NUM_REQ-1 bursts after its valid is seen in ARB_IDLE.

Decomposition:
- Package fabric_port_pkg:
  - typedef enum arb_state_t {ARB_IDLE, ARB_LOCKED}
  - function rtl_width(WIDTH_NOC) = 4*WIDTH_NOC
  - function id_width(n) = max(1,$clog2(n))
- Sub-module rr_priority_select: combinational.
  - Inputs: NUM_REQ-bit request vector, start pointer.
  - Outputs: grant index and any_valid.
  - Implemented by double-width rotate and first-one search.

Test Plan:
- Reset, then all four requesters valid with last=1 and rtl_ready_in=1 → grants in order 0,1,2,3,0.
  - One packet per cycle; rtl_grant_id_out trails each grant by 1 cycle.
- Requester 1 sends a 3-packet burst (last on the 3rd) while requesters 0 and 2 are valid → output ids 1,1,1,2.
  - req_ready_out[0] and req_ready_out[2] stay 0 during the burst.
- rtl_ready_in=0 for 5 cycles with rtl_valid_out=1 → rtl_packet_out and id stable, all req_ready_out=0.
  - Releasing rtl_ready_in gives a transfer in the same cycle, with no bubble.
- Owner 2 drops valid for 4 cycles mid-burst while requester 3 is valid → no output and no grant to 3.
  - Burst resumes and completes before 3 is served.
- NUM_REQ=3, rr_ptr at 2, only requester 0 valid → grant 0, next rr_ptr=1.
  - Then requesters 1 and 2 both valid → grant 1 first.
- Assert rst=0 mid-burst with rtl_valid_out=1 → outputs 0 immediately (async).
  - After release, requester 0 wins from ARB_IDLE with rr_ptr=0.

Source files
------------

// File: rtl/fabric_port_arbiter_pkg.sv
// Shared types and width helpers for the fabric port arbiter.
package fabric_port_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int rtl_width(input int width_noc);
    return 4 * width_noc;
  endfunction

  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fabric_port_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first set request at or after start_i, wrapping modulo NUM_REQ.
module rr_priority_select
  import fabric_port_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    start_i,
  output logic [ID_W-1:0]    grant_o,
  output logic               any_o
);

  localparam int SW = ID_W + 1;

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [ID_W-1:0]      w_off;
  logic [SW-1:0]        w_sum;

  always_comb begin
    w_dbl = {req_i, req_i} >> start_i;
    w_rot = w_dbl[NUM_REQ-1:0];
    // Upper half of the shifted copy only repeats request bits, so OR-ing it all is |req_i.
    any_o = |w_dbl;
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = ID_W'(k);
    end
    w_sum = {1'b0, start_i} + {1'b0, w_off};
    if (w_sum >= SW'(NUM_REQ)) w_sum = w_sum - SW'(NUM_REQ);
    grant_o = w_sum[ID_W-1:0];
  end

endmodule

// File: rtl/fabric_port_arbiter.sv
// Round-robin, burst-atomic arbiter merging NUM_REQ packet sources onto one registered fabric port.
//   state      | meaning
//   ARB_IDLE   | round-robin pick from rr_ptr each cycle the output can load
//   ARB_LOCKED | only r_owner may transfer until it sends a packet marked last
module fabric_port_arbiter
  import fabric_port_pkg::*;
#(
  parameter int WIDTH_NOC    = 8,
  parameter int WIDTH_RTL    = rtl_width(WIDTH_NOC),
  parameter int NUM_REQ      = 4,
  parameter int REQ_ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*WIDTH_RTL-1:0] req_packet_in,
  input  logic [NUM_REQ-1:0]           req_valid_in,
  input  logic [NUM_REQ-1:0]           req_last_in,
  output logic [NUM_REQ-1:0]           req_ready_out,
  output logic [WIDTH_RTL-1:0]         rtl_packet_out,
  output logic                         rtl_valid_out,
  output logic                         rtl_last_out,
  output logic [REQ_ID_WIDTH-1:0]      rtl_grant_id_out,
  input  logic                         rtl_ready_in
);

  arb_state_t              r_state;
  logic [REQ_ID_WIDTH-1:0] r_rr_ptr;
  logic [REQ_ID_WIDTH-1:0] r_owner;

  logic [REQ_ID_WIDTH-1:0] w_grant;
  logic                    w_any;
  logic                    w_load;
  logic [REQ_ID_WIDTH-1:0] w_sel_id;
  logic                    w_xfer;
  logic                    w_last;
  logic [WIDTH_RTL-1:0]    w_pkt;

  function automatic logic [REQ_ID_WIDTH-1:0] next_id(input logic [REQ_ID_WIDTH-1:0] id);
    return (id == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (REQ_ID_WIDTH)
  ) u_sel (
    .req_i   (req_valid_in),
    .start_i (r_rr_ptr),
    .grant_o (w_grant),
    .any_o   (w_any)
  );

  assign w_load = !rtl_valid_out || rtl_ready_in;

  // Ready is a function of state, pointer, valids and output backpressure only.
  always_comb begin
    w_sel_id      = (r_state == ARB_LOCKED) ? r_owner : w_grant;
    req_ready_out = '0;
    if (rst) begin
      if (r_state == ARB_LOCKED) req_ready_out[r_owner] = w_load;
      else if (w_any && w_load)  req_ready_out[w_grant] = 1'b1;
    end
  end

  assign w_xfer = |(req_valid_in & req_ready_out);
  assign w_last = req_last_in[w_sel_id];
  assign w_pkt  = req_packet_in[w_sel_id*WIDTH_RTL +: WIDTH_RTL];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= ARB_IDLE;
      r_rr_ptr         <= '0;
      r_owner          <= '0;
      rtl_valid_out    <= 1'b0;
      rtl_packet_out   <= '0;
      rtl_last_out     <= 1'b0;
      rtl_grant_id_out <= '0;
    end else begin
      if (w_xfer) begin
        rtl_valid_out    <= 1'b1;
        rtl_packet_out   <= w_pkt;
        rtl_last_out     <= w_last;
        rtl_grant_id_out <= w_sel_id;
      end else if (rtl_ready_in) begin
        rtl_valid_out <= 1'b0;
      end

      case (r_state)
        ARB_IDLE: begin
          if (w_xfer) begin
            if (w_last) begin
              r_rr_ptr <= next_id(w_grant);
            end else begin
              r_owner <= w_grant;
              r_state <= ARB_LOCKED;
            end
          end
        end
        ARB_LOCKED: begin
          if (w_xfer && w_last) begin
            r_rr_ptr <= next_id(r_owner);
            r_state  <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fabric_port_arbiter.sv
// Scoreboard bench for fabric_port_arbiter: directed scenarios plus random traffic against a queue model.
module tb_fabric_port_arbiter;
  import fabric_port_pkg::*;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;
  localparam int N3  = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [N*W-1:0] req_packet_in;
  logic [N-1:0]   req_valid_in, req_last_in, req_ready_out;
  logic [W-1:0]   rtl_packet_out;
  logic           rtl_valid_out, rtl_last_out, rtl_ready_in;
  logic [IDW-1:0] rtl_grant_id_out;

  logic [N3*W-1:0] req_packet_in3;
  logic [N3-1:0]   req_valid_in3, req_last_in3, req_ready_out3;
  logic [W-1:0]    rtl_packet_out3;
  logic            rtl_valid_out3, rtl_last_out3, rtl_ready_in3;
  logic [IDW-1:0]  rtl_grant_id_out3;

  fabric_port_arbiter #(.WIDTH_NOC(8), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_packet_in(req_packet_in), .req_valid_in(req_valid_in), .req_last_in(req_last_in),
    .req_ready_out(req_ready_out), .rtl_packet_out(rtl_packet_out), .rtl_valid_out(rtl_valid_out),
    .rtl_last_out(rtl_last_out), .rtl_grant_id_out(rtl_grant_id_out), .rtl_ready_in(rtl_ready_in)
  );

  fabric_port_arbiter #(.WIDTH_NOC(8), .NUM_REQ(N3)) dut3 (
    .clk(clk), .rst(rst),
    .req_packet_in(req_packet_in3), .req_valid_in(req_valid_in3), .req_last_in(req_last_in3),
    .req_ready_out(req_ready_out3), .rtl_packet_out(rtl_packet_out3), .rtl_valid_out(rtl_valid_out3),
    .rtl_last_out(rtl_last_out3), .rtl_grant_id_out(rtl_grant_id_out3), .rtl_ready_in(rtl_ready_in3)
  );

  typedef struct packed {
    logic [W-1:0]   pkt;
    logic           last;
    logic [IDW-1:0] id;
  } item_t;

  item_t sb_q[$];
  item_t mon_e;
  int total = 0;
  int bad   = 0;

  // Reference model: burst owner (-1 when free), round-robin start, and whether the output holds a packet.
  int m_rr    = 0;
  int m_owner = -1;
  bit m_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_ready(input logic [N-1:0] v, input logic r);
    logic [N-1:0] e;
    e = '0;
    if (m_valid && !r) return e;
    if (m_owner >= 0) return N'(1) << m_owner;
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) return N'(1) << ((m_rr + k) % N);
    end
    return e;
  endfunction

  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input logic r,
                       output logic [N-1:0] rdy_act);
    logic [N-1:0] exp_rdy;
    int id;
    item_t it;
    @(negedge clk);
    req_valid_in = v;
    req_last_in  = l;
    rtl_ready_in = r;
    for (int i = 0; i < N; i++) req_packet_in[i*W +: W] = {8'(i), 24'($urandom)};
    #1;
    check("out_valid", 64'(rtl_valid_out), 64'(m_valid));
    exp_rdy = model_ready(v, r);
    check("req_ready", 64'(req_ready_out), 64'(exp_rdy));
    rdy_act = req_ready_out;
    id = -1;
    for (int i = 0; i < N; i++) if (exp_rdy[i] && v[i]) id = i;
    if (id >= 0) begin
      it.pkt  = req_packet_in[id*W +: W];
      it.last = l[id];
      it.id   = IDW'(id);
      sb_q.push_back(it);
      m_valid = 1'b1;
      if (l[id]) begin
        m_owner = -1;
        m_rr    = (id + 1) % N;
      end else begin
        m_owner = id;
      end
    end else if (r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic c3(input logic [N3-1:0] v, output logic [N3-1:0] rdy);
    @(negedge clk);
    req_valid_in3 = v;
    #1;
    rdy = req_ready_out3;
  endtask

  // Monitor: pops one expected packet per output handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && rtl_valid_out && rtl_ready_in) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_unexpected: got id %0d pkt %0h, expected nothing", rtl_grant_id_out, rtl_packet_out);
        end else begin
          mon_e = sb_q.pop_front();
          check("out_pkt",  64'(rtl_packet_out),   64'(mon_e.pkt));
          check("out_last", 64'(rtl_last_out),     64'(mon_e.last));
          check("out_id",   64'(rtl_grant_id_out), 64'(mon_e.id));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0]  rdy;
    logic [N3-1:0] rdy3;
    logic [W-1:0]  held_pkt;
    logic [IDW-1:0] held_id;

    req_packet_in  = '0;
    req_valid_in   = '1;
    req_last_in    = '0;
    rtl_ready_in   = 1'b1;
    req_packet_in3 = {32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000};
    req_valid_in3  = '0;
    req_last_in3   = '1;
    rtl_ready_in3  = 1'b1;
    held_pkt       = '0;
    held_id        = '0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 64'(rtl_valid_out),    64'(0));
    check("rst_pkt",   64'(rtl_packet_out),   64'(0));
    check("rst_last",  64'(rtl_last_out),     64'(0));
    check("rst_id",    64'(rtl_grant_id_out), 64'(0));
    check("rst_ready", 64'(req_ready_out),    64'(0));
    @(negedge clk);
    req_valid_in = '0;
    rst = 1'b1;

    // Three-requester instance: wrap from rr_ptr=2 to requester 0, then pointer lands on 1.
    c3(3'b001, rdy3); check("n3_g0",  64'(rdy3), 64'(3'b001));
    c3(3'b010, rdy3); check("n3_g1",  64'(rdy3), 64'(3'b010));
    c3(3'b001, rdy3); check("n3_wrap", 64'(rdy3), 64'(3'b001));
    c3(3'b110, rdy3); check("n3_next", 64'(rdy3), 64'(3'b010));
    check("n3_id0",  64'(rtl_grant_id_out3), 64'(0));
    check("n3_pkt0", 64'(rtl_packet_out3),   64'(32'hC0C0_0000));
    c3(3'b000, rdy3);
    check("n3_id1",  64'(rtl_grant_id_out3), 64'(1));

    // All four single-packet bursts: strict rotation 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      cycle(4'hF, 4'hF, 1'b1, rdy);
      check("rr_order", 64'(rdy), 64'(N'(1) << (k % N)));
    end

    // Requester 1 three-packet burst while 0 and 2 wait.
    cycle(4'b0111, 4'b1101, 1'b1, rdy); check("burst_a", 64'(rdy), 64'(4'b0010));
    cycle(4'b0111, 4'b1101, 1'b1, rdy); check("burst_b", 64'(rdy), 64'(4'b0010));
    cycle(4'b0111, 4'b1111, 1'b1, rdy); check("burst_c", 64'(rdy), 64'(4'b0010));
    cycle(4'b0111, 4'b1111, 1'b1, rdy); check("burst_next", 64'(rdy), 64'(4'b0100));

    // Output stall for five cycles, then release with no bubble.
    cycle(4'hF, 4'hF, 1'b1, rdy); check("pre_stall", 64'(rdy), 64'(4'b1000));
    for (int k = 0; k < 5; k++) begin
      cycle(4'hF, 4'hF, 1'b0, rdy);
      if (k == 0) begin
        held_pkt = rtl_packet_out;
        held_id  = rtl_grant_id_out;
      end
      check("stall_ready", 64'(rdy), 64'(0));
      check("stall_pkt",   64'(rtl_packet_out),   64'(held_pkt));
      check("stall_id",    64'(rtl_grant_id_out), 64'(held_id));
    end
    check("stall_held_id", 64'(held_id), 64'(3));
    cycle(4'hF, 4'hF, 1'b1, rdy); check("no_bubble", 64'(rdy), 64'(4'b0001));

    // Owner 2 goes quiet mid-burst; requester 3 must not be served until 2 finishes.
    cycle(4'b0100, 4'b0000, 1'b1, rdy); check("lock2", 64'(rdy), 64'(4'b0100));
    for (int k = 0; k < 4; k++) begin
      cycle(4'b1000, 4'hF, 1'b1, rdy);
      check("gap_ready", 64'(rdy), 64'(4'b0100));
    end
    cycle(4'b1100, 4'b0100, 1'b1, rdy); check("resume2", 64'(rdy), 64'(4'b0100));
    cycle(4'b1000, 4'hF, 1'b1, rdy);    check("then3",   64'(rdy), 64'(4'b1000));

    // Asynchronous reset mid-burst with a packet on the output.
    cycle(4'b0001, 4'b0000, 1'b1, rdy); check("lock0", 64'(rdy), 64'(4'b0001));
    @(negedge clk);
    rtl_ready_in = 1'b0;
    req_valid_in = '0;
    #3;
    rst = 1'b0;
    #1;
    check("arst_valid", 64'(rtl_valid_out),    64'(0));
    check("arst_pkt",   64'(rtl_packet_out),   64'(0));
    check("arst_id",    64'(rtl_grant_id_out), 64'(0));
    sb_q.delete();
    m_valid = 1'b0;
    m_owner = -1;
    m_rr    = 0;
    @(negedge clk);
    req_valid_in = '1;
    #1;
    check("arst_ready", 64'(req_ready_out), 64'(0));
    @(negedge clk);
    req_valid_in = '0;
    rst = 1'b1;
    cycle(4'hF, 4'hF, 1'b1, rdy); check("post_rst", 64'(rdy), 64'(4'b0001));

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cycle(N'($urandom), N'($urandom), 1'b1 && (($urandom % 4) != 0), rdy);
    end
    repeat (4) cycle(4'h0, 4'h0, 1'b1, rdy);
    check("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
